// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - IF/D arbiter and three-phase sequencer for pipe_mem
// D has fixed priority; a starvation counter forces IF after AGE_LIMIT D grants.
module pipe_mem_arbiter #(
   parameter int unsigned AGE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_w,
   input  logic        d_h,
   input  logic        d_b,
   input  logic        d_z,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_ena,
   output logic        m_wena,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_w,
   output logic        m_h,
   output logic        m_b,
   output logic        m_z,
   input  logic [31:0] m_rdata,
   input  logic        m_aerr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   localparam logic [3:0] AGE_MAX = AGE_LIMIT[3:0];

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_own_d;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic        r_w;
   logic        r_h;
   logic        r_b;
   logic        r_z;
   logic [31:0] r_rdata;
   logic        r_aerr;
   logic [3:0]  r_starve;

   logic        w_sel_d;
   logic        w_sel_if;
   logic        w_grant;
   logic [31:0] w_resp_data;

   // D loses only when IF is waiting and has already yielded AGE_LIMIT times.
   assign w_sel_d  = d_req && ((r_starve < AGE_MAX) || !if_req);
   assign w_sel_if = if_req && !w_sel_d;
   assign w_grant  = (r_state == S_IDLE) && (w_sel_d || w_sel_if);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_resp_data = (r_aerr || r_we) ? 32'h0 : r_rdata;
      m_ena       = 1'b0;
      m_wena      = 1'b0;
      m_addr      = 32'h0;
      m_wdata     = 32'h0;
      m_w         = 1'b0;
      m_h         = 1'b0;
      m_b         = 1'b0;
      m_z         = 1'b0;
      if_ack      = 1'b0;
      if_rdata    = 32'h0;
      if_err      = 1'b0;
      d_ack       = 1'b0;
      d_rdata     = 32'h0;
      d_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_RESP;
            m_ena       = 1'b1;
            m_wena      = r_we;
            m_addr      = r_addr;
            m_wdata     = r_wdata;
            m_w         = r_w;
            m_h         = r_h;
            m_b         = r_b;
            m_z         = r_z;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            if (r_own_d) begin
               d_ack   = 1'b1;
               d_rdata = w_resp_data;
               d_err   = r_aerr;
            end else begin
               if_ack   = 1'b1;
               if_rdata = w_resp_data;
               if_err   = r_aerr;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // IF is always a plain word read, so its controls are fixed at latch time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_own_d <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_we    <= 1'b0;
         r_w     <= 1'b0;
         r_h     <= 1'b0;
         r_b     <= 1'b0;
         r_z     <= 1'b0;
      end else if (w_grant) begin
         if (w_sel_d) begin
            r_own_d <= 1'b1;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_we    <= d_we;
            r_w     <= d_w;
            r_h     <= d_h;
            r_b     <= d_b;
            r_z     <= d_z;
         end else begin
            r_own_d <= 1'b0;
            r_addr  <= if_addr;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_w     <= 1'b1;
            r_h     <= 1'b0;
            r_b     <= 1'b0;
            r_z     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 32'h0;
         r_aerr  <= 1'b0;
      end else if (r_state == S_ISSUE) begin
         r_rdata <= m_rdata;
         r_aerr  <= m_aerr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve <= 4'd0;
      end else if (r_state == S_IDLE) begin
         if (!if_req || w_sel_if) begin
            r_starve <= 4'd0;
         end else if (w_sel_d && (r_starve < AGE_MAX)) begin
            r_starve <= r_starve + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - randomized self-checking bench for pipe_mem_arbiter
// A word-array memory stands in for pipe_mem; a byte-array model predicts every response.
module tb_pipe_mem_arbiter;

   localparam int AGE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic [31:0] d_wdata = 32'h0;
   logic        d_w = 1'b0;
   logic        d_h = 1'b0;
   logic        d_b = 1'b0;
   logic        d_z = 1'b0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        m_ena;
   logic        m_wena;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_w;
   logic        m_h;
   logic        m_b;
   logic        m_z;
   logic [31:0] m_rdata;
   logic        m_aerr;

   int n_checks = 0;
   int n_errors = 0;

   pipe_mem_arbiter #(.AGE_LIMIT(AGE)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_w(d_w), .d_h(d_h), .d_b(d_b), .d_z(d_z),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .m_ena(m_ena), .m_wena(m_wena), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_w(m_w), .m_h(m_h), .m_b(m_b), .m_z(m_z),
      .m_rdata(m_rdata), .m_aerr(m_aerr)
   );

   always #5 clk = ~clk;

   logic [137:0] all_outs;
   assign all_outs = {if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
                      m_ena, m_wena, m_addr, m_wdata, m_w, m_h, m_b, m_z};

   // pipe_mem stand-in: little-endian words, extends loads, suppresses misaligned writes
   logic [31:0] mem [256];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = 8'h0;
   logic [31:0] pre_data = 32'h0;
   logic        mm_bad;
   logic [31:0] mm_word;
   logic [15:0] mm_half;
   logic [7:0]  mm_byte;

   always_comb begin
      mm_bad  = m_ena && ((m_w && (m_addr[1:0] != 2'b00)) || (m_h && m_addr[0]));
      mm_word = mem[m_addr[9:2]];
      mm_half = m_addr[1] ? mm_word[31:16] : mm_word[15:0];
      mm_byte = mm_word[{m_addr[1:0], 3'b000} +: 8];
      m_aerr  = mm_bad;
      m_rdata = 32'h0;
      if (m_ena) begin
         if (mm_bad)   m_rdata = 32'hBAD0_BAD0;
         else if (m_w) m_rdata = mm_word;
         else if (m_h) m_rdata = m_z ? {16'h0, mm_half} : {{16{mm_half[15]}}, mm_half};
         else if (m_b) m_rdata = m_z ? {24'h0, mm_byte} : {{24{mm_byte[7]}}, mm_byte};
      end
   end

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_idx] <= pre_data;
      end else if (m_ena && m_wena && !mm_bad) begin
         if (m_w)                 mem[m_addr[9:2]] <= m_wdata;
         else if (m_h && m_addr[1]) mem[m_addr[9:2]][31:16] <= m_wdata[15:0];
         else if (m_h)            mem[m_addr[9:2]][15:0] <= m_wdata[15:0];
         else if (m_b)            mem[m_addr[9:2]][{m_addr[1:0], 3'b000} +: 8] <= m_wdata[7:0];
      end
   end

   // reference model: flat byte array, accesses computed from size/extend rules
   logic [7:0] ref_bytes [1024];

   function automatic logic ref_bad(input logic [31:0] a, input int n);
      return ((n == 4) && (a[1:0] != 2'b00)) || ((n == 2) && a[0]);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic z);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
         v = v | (32'(ref_bytes[(int'(a[9:0]) + i) % 1024]) << (8 * i));
      end
      if (!z && (n == 2) && v[15]) v = v | 32'hFFFF_0000;
      if (!z && (n == 1) && v[7])  v = v | 32'hFFFF_FF00;
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
      for (int i = 0; i < n; i++) begin
         ref_bytes[(int'(a[9:0]) + i) % 1024] = wd[8 * i +: 8];
      end
   endtask

   int          obs_ena_cyc;
   int          obs_ack_cyc;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [31:0] obs_rdata;
   logic [3:0]  obs_ctl;
   logic        obs_wena;
   logic        obs_err;
   logic        obs_wrong_ack;
   logic        obs_leak;

   // one requester transaction; requester fields are scrambled once latched
   task automatic drive_txn(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sz);
      @(negedge clk);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
         {d_w, d_h, d_b, d_z} = sz;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      obs_ena_cyc = 0; obs_ack_cyc = 0; obs_wrong_ack = 1'b0; obs_leak = 1'b0;
      obs_addr = 32'h0; obs_wdata = 32'h0; obs_rdata = 32'h0; obs_ctl = 4'h0;
      obs_wena = 1'b0; obs_err = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (m_ena && (obs_ena_cyc == 0)) begin
            obs_ena_cyc = k; obs_addr = m_addr; obs_wdata = m_wdata;
            obs_wena = m_wena; obs_ctl = {m_w, m_h, m_b, m_z};
         end
         if ((k != 1) && (m_ena || m_wena || (m_addr != 32'h0) || (m_wdata != 32'h0) ||
                          ({m_w, m_h, m_b, m_z} != 4'h0)))
            obs_leak = 1'b1;
         if (k == 1) begin
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_we = 1'($urandom_range(0, 1));
         end
         if (is_d ? if_ack : d_ack) obs_wrong_ack = 1'b1;
         if (is_d ? d_ack : if_ack) begin
            obs_ack_cyc = k;
            obs_rdata   = is_d ? d_rdata : if_rdata;
            obs_err     = is_d ? d_err : if_err;
            break;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic load_memory();
      logic [31:0] v;
      pre_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         v = (i == 4) ? 32'hDEAD_BEEF : $urandom;
         pre_idx = 8'(i); pre_data = v;
         for (int k = 0; k < 4; k++) ref_bytes[4 * i + k] = v[8 * k +: 8];
         @(negedge clk);
      end
      pre_en = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      n_checks++;
      if (all_outs !== '0) begin n_errors++; $display("FAIL reset_outs got %h exp 0", all_outs); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (all_outs !== '0) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_errors++; $display("FAIL idle_quiet got activity exp none"); end
   endtask

   task automatic test_if_read();
      drive_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'b1000);
      n_checks++;
      if (obs_ena_cyc !== 1) begin n_errors++; $display("FAIL if_ena_cycle got %0d exp 1", obs_ena_cyc); end
      n_checks++;
      if (obs_addr !== 32'h10) begin n_errors++; $display("FAIL if_m_addr got %h exp 00000010", obs_addr); end
      n_checks++;
      if ({obs_wena, obs_ctl} !== 5'b0_1000) begin n_errors++; $display("FAIL if_m_ctl got %b exp 01000", {obs_wena, obs_ctl}); end
      n_checks++;
      if (obs_ack_cyc !== 2) begin n_errors++; $display("FAIL if_ack_cycle got %0d exp 2", obs_ack_cyc); end
      n_checks++;
      if ({obs_err, obs_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL if_rdata got %b/%h exp 0/deadbeef", obs_err, obs_rdata); end
      n_checks++;
      if (obs_wrong_ack !== 1'b0) begin n_errors++; $display("FAIL if_wrong_ack got 1 exp 0"); end
   endtask

   task automatic test_byte_store_load();
      drive_txn(1'b1, 1'b1, 32'h21, 32'h0000_00F0, 4'b0010);
      ref_store(32'h21, 1, 32'h0000_00F0);
      n_checks++;
      if ({obs_ack_cyc, obs_err, obs_rdata} !== {32'd2, 1'b0, 32'h0}) begin n_errors++; $display("FAIL sb_ack got cyc %0d err %b rd %h exp 2/0/0", obs_ack_cyc, obs_err, obs_rdata); end
      drive_txn(1'b1, 1'b0, 32'h21, 32'h0, 4'b0010);
      n_checks++;
      if (obs_rdata !== 32'hFFFF_FFF0) begin n_errors++; $display("FAIL lb_signed got %h exp fffffff0", obs_rdata); end
      drive_txn(1'b1, 1'b0, 32'h21, 32'h0, 4'b0011);
      n_checks++;
      if (obs_rdata !== 32'h0000_00F0) begin n_errors++; $display("FAIL lb_zero got %h exp 000000f0", obs_rdata); end
   endtask

   task automatic test_misaligned();
      logic [31:0] old;
      old = ref_load(32'h20, 4, 1'b0);
      drive_txn(1'b1, 1'b1, 32'h22, 32'h1234_5678, 4'b1000);
      n_checks++;
      if ({obs_ack_cyc, obs_err, obs_rdata} !== {32'd2, 1'b1, 32'h0}) begin n_errors++; $display("FAIL misal_store got cyc %0d err %b rd %h exp 2/1/0", obs_ack_cyc, obs_err, obs_rdata); end
      drive_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'b1000);
      n_checks++;
      if ({obs_err, obs_rdata} !== {1'b0, old}) begin n_errors++; $display("FAIL misal_old got %b/%h exp 0/%h", obs_err, obs_rdata, old); end
   endtask

   task automatic test_random();
      logic        is_d, we, z, mis, bad;
      int          n;
      logic [31:0] a, wd, exp_rd;
      logic [3:0]  sz;
      for (int t = 0; t < 40; t++) begin
         is_d = 1'($urandom_range(0, 1));
         we = 1'b0; z = 1'b0; n = 4;
         mis = ($urandom_range(0, 4) == 0);
         wd = $urandom;
         if (is_d) begin
            we = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
               0:       n = 4;
               1:       n = 2;
               default: n = 1;
            endcase
         end
         a = 32'($urandom_range(0, 255)) << 2;
         if (n == 2) a = a + (32'($urandom_range(0, 1)) << 1);
         if (n == 1) a = a + 32'($urandom_range(0, 3));
         if (mis && (n != 1)) a = a + 32'd1;
         sz = {n == 4, n == 2, n == 1, z};
         bad = ref_bad(a, n);
         exp_rd = (bad || we) ? 32'h0 : ref_load(a, n, z);
         drive_txn(is_d, we, a, wd, sz);
         n_checks++;
         if ({obs_ena_cyc, obs_ack_cyc} !== {32'd1, 32'd2}) begin n_errors++; $display("FAIL rnd%0d_latency got ena %0d ack %0d exp 1/2", t, obs_ena_cyc, obs_ack_cyc); end
         n_checks++;
         if ({obs_addr, obs_wena, obs_ctl} !== {a, is_d && we, sz}) begin n_errors++; $display("FAIL rnd%0d_issue got %h/%b/%b exp %h/%b/%b", t, obs_addr, obs_wena, obs_ctl, a, is_d && we, sz); end
         if (is_d && we) begin
            n_checks++;
            if (obs_wdata !== wd) begin n_errors++; $display("FAIL rnd%0d_wdata got %h exp %h", t, obs_wdata, wd); end
         end
         n_checks++;
         if ({obs_err, obs_rdata} !== {bad, exp_rd}) begin n_errors++; $display("FAIL rnd%0d_resp got %b/%h exp %b/%h", t, obs_err, obs_rdata, bad, exp_rd); end
         n_checks++;
         if ({obs_wrong_ack, obs_leak} !== 2'b00) begin n_errors++; $display("FAIL rnd%0d_quiet got wrong_ack %b leak %b exp 0/0", t, obs_wrong_ack, obs_leak); end
         if (is_d && we && !bad) ref_store(a, n, wd);
      end
   endtask

   task automatic test_starvation();
      int   acks, d_run;
      logic exp_if;
      acks = 0; d_run = 0;
      repeat (2) @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; {d_w, d_h, d_b, d_z} = 4'b1000;
      if_req = 1'b1; if_addr = 32'h80;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (if_ack || d_ack) begin
            exp_if = (d_run == AGE);
            n_checks++;
            if (if_ack && d_ack) begin n_errors++; $display("FAIL starve_dual_ack at cycle %0d got both exp one", c); end
            n_checks++;
            if (if_ack !== exp_if) begin n_errors++; $display("FAIL starve_owner%0d got if_ack %b exp %b", acks, if_ack, exp_if); end
            n_checks++;
            if (c !== 2 + 3 * acks) begin n_errors++; $display("FAIL starve_spacing%0d got cycle %0d exp %0d", acks, c, 2 + 3 * acks); end
            d_run = exp_if ? 0 : d_run + 1;
            acks++;
            if (acks == 15) break;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      n_checks++;
      if (acks !== 15) begin n_errors++; $display("FAIL starve_timeout got %0d acks exp 15", acks); end
   endtask

   task automatic test_if_drop();
      int   d_acks, d_after;
      logic raised, if_seen;
      d_acks = 0; d_after = 0; raised = 1'b0; if_seen = 1'b0;
      repeat (2) @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; {d_w, d_h, d_b, d_z} = 4'b1000;
      if_req = 1'b1; if_addr = 32'h84;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (if_ack) begin if_seen = 1'b1; break; end
         if (d_ack) begin
            d_acks++;
            if (raised) d_after++;
            if (d_acks == 2) if_req = 1'b0;
            if (d_acks == 3) begin if_req = 1'b1; raised = 1'b1; end
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      n_checks++;
      if ({if_seen, raised} !== 2'b11) begin n_errors++; $display("FAIL drop_if_grant got seen %b raised %b exp 1/1", if_seen, raised); end
      n_checks++;
      if (d_after !== AGE) begin n_errors++; $display("FAIL drop_wait got %0d D grants exp %0d", d_after, AGE); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_rd, rd;
      int          ena_c, ack_c;
      @(negedge clk);
      exp_rd = ref_load(32'h10, 4, 1'b0);
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      n_checks++;
      if (m_ena !== 1'b1) begin n_errors++; $display("FAIL rstmid_issue got m_ena %b exp 1", m_ena); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (all_outs !== '0) begin n_errors++; $display("FAIL rstmid_async got %h exp 0", all_outs); end
      @(negedge clk);
      n_checks++;
      if (all_outs !== '0) begin n_errors++; $display("FAIL rstmid_next got %h exp 0", all_outs); end
      rst = 1'b0;
      ena_c = 0; ack_c = 0; rd = 32'h0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (m_ena && (ena_c == 0)) ena_c = k;
         if (if_ack) begin ack_c = k; rd = if_rdata; break; end
      end
      if_req = 1'b0;
      n_checks++;
      if ({ena_c, ack_c} !== {32'd1, 32'd2}) begin n_errors++; $display("FAIL rstmid_reissue got ena %0d ack %0d exp 1/2", ena_c, ack_c); end
      n_checks++;
      if (rd !== exp_rd) begin n_errors++; $display("FAIL rstmid_rdata got %h exp %h", rd, exp_rd); end
   endtask

   initial begin
      load_memory();
      test_reset();
      test_if_read();
      test_byte_store_load();
      test_misaligned();
      test_random();
      test_starvation();
      test_if_drop();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Two-requester arbiter and sequencer for the single-ported pipeline data memory (`pipe_mem`). It shares the memory between the instruction-fetch requester (IF, always word reads) and the data requester (D, loads and stores of word, halfword or byte, signed or zero-extended). Each access runs as a three-phase transaction: arbitrate, issue, respond. D has fixed priority, and a starvation limit guarantees IF forward progress. The block sits between the pipeline stages and `pipe_mem`, and it reports `pipe_mem`'s address-alignment error back to the requester that caused it.

## Interface
Parameters:
- `AGE_LIMIT`, default 4: consecutive D grants allowed while IF waits before IF is forced. Legal range is 1–15.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `if_req` in 1: IF request; held high until `if_ack`.
- `if_addr` in 32: IF word address (byte-addressed).
- `if_ack` out 1: one-cycle IF completion pulse.
- `if_rdata` out 32: IF read data; valid while `if_ack` is high.
- `if_err` out 1: IF address error; valid while `if_ack` is high.
- `d_req` in 1: D request; held high until `d_ack`.
- `d_we` in 1: D store (1) or load (0).
- `d_addr` in 32: D byte address.
- `d_wdata` in 32: D store data.
- `d_w`, `d_h`, `d_b`, `d_z` in 1 each: D access size (word, halfword, byte) and zero-extend flag.
- `d_ack` out 1: one-cycle D completion pulse.
- `d_rdata` out 32: D load data; valid while `d_ack` is high.
- `d_err` out 1: D address error; valid while `d_ack` is high.
- `m_ena`, `m_wena` out 1: memory enable and write enable.
- `m_addr`, `m_wdata` out 32: memory address and write data.
- `m_w`, `m_h`, `m_b`, `m_z` out 1: size and extend controls to memory.
- `m_rdata` in 32: memory read data (already extended by memory).
- `m_aerr` in 1: memory AddressErr.

## Operation
The block is a three-state FSM with states IDLE, ISSUE and RESP.

IDLE
- If `d_req` is high and `starve_cnt` < `AGE_LIMIT` (or `if_req` is low), D is selected.
- Otherwise, if `if_req` is high, IF is selected.
- The selected request's address, data and controls are latched into the request registers, along with the owner bit.
- The FSM moves to ISSUE. With no request it stays in IDLE.

ISSUE
- `m_ena`=1. The `m_*` outputs are driven only from the latched registers.
- For IF: `m_wena`=0, `m_w`=1, `m_h`=`m_b`=`m_z`=0.
- For D: `m_wena`=`d_we` (latched), and the size and extend controls are the latched values.
- `m_rdata` and `m_aerr` are captured at the end of the cycle.
- The FSM moves to RESP.

RESP
- The owner's ack is asserted. Its rdata is the captured `m_rdata`, or 0 if the error was captured or the access was a store. Its err is the captured `m_aerr`.
- The FSM moves to IDLE.

Starvation counter `starve_cnt`, 4 bits:
- Increments on a D grant while `if_req` is high.
- Clears on an IF grant.
- Clears in any IDLE cycle with `if_req` low.
- Saturates at `AGE_LIMIT`.

Address errors:
- The memory suppresses its own enable when the address is misaligned, so an erroneous store writes nothing.
- The arbiter still completes the transaction with err=1.

Requesters:
- Requester inputs are sampled only in IDLE; changes to them during ISSUE or RESP have no effect.
- A req still high in the cycle after its ack counts as a new request.

## Timing
- Latency: a request seen in IDLE at cycle N gets its memory access in cycle N+1 and its ack in cycle N+2.
- Throughput: at most one access every 3 cycles.
- `m_*` outputs are 0 outside ISSUE.
- Ack outputs are 0 outside RESP. `if_ack` and `d_ack` are never high together.
- Simultaneous `if_req` and `d_req` in IDLE: D wins unless `starve_cnt` equals `AGE_LIMIT`.
- Reset value of every output is 0. Reset also sets the state to IDLE, `starve_cnt` to 0, and clears the latched registers.
- Reset asserted mid-transaction aborts the transaction with no ack. A store already in ISSUE may or may not have been written. Requesters reissue after reset.

## Test plan
- Single IF read, `if_addr`=0x10, memory word 0xDEADBEEF: `m_ena` high in cycle 1 with `m_addr`=0x10 and `m_w`=1; `if_ack`=1 in cycle 2 with `if_rdata`=0xDEADBEEF and `if_err`=0.
- D byte store then signed byte load:
  - Store at addr 0x21, data 0x000000F0, `d_b`=1.
  - Load the same address with `d_b`=1, `d_z`=0.
  - Required: `d_rdata`=0xFFFFFFF0. With `d_z`=1, `d_rdata`=0x000000F0.
- Misaligned D word store at addr 0x22 with `m_aerr`=1: `d_ack` and `d_err`=1, `d_rdata`=0. A following word load of 0x20 returns the old contents.
- Both requesters held high continuously with `AGE_LIMIT`=4: grant sequence D,D,D,D,IF repeating, each grant 3 cycles apart. No two acks in the same cycle.
- `if_req` drops during a D burst: `starve_cnt` clears. IF re-raised later gets a full `AGE_LIMIT` wait before being forced.
- `rst` pulsed during ISSUE of an IF read: no `if_ack`, all outputs 0 next cycle. The FSM is in IDLE and the reissued request completes normally 2 cycles after it is sampled.
